// File: rtl/log_spawner.sv
// log_spawner: owns the river log pool. Paced by timer_done, it scans the
// lanes one per cycle. A lane whose gap counter expires claims its lowest
// free slot and loads that slot's spawn offsets. Exit pulses from the log
// movers free slots again.
//
// state | meaning
// IDLE  | spawning frozen, waiting for game_run
// RUN   | waiting for a spawn tick (or a held pending tick)
// SCAN  | visiting lane r_lane this cycle, lanes 0..NUM_LANES-1 in order
module log_spawner #(
  parameter int NUM_OF_LOGS   = 30,
  parameter int NUM_LANES     = 5,
  parameter int LOGS_PER_LANE = 6,
  parameter int FIRST_LANE_Y  = 64,
  parameter int LANE_HEIGHT   = 32,
  parameter int RIGHT_EDGE_X  = 448,
  parameter int MIN_GAP       = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   game_run,
  input  logic                   timer_done,
  input  logic [3:0]             random_0_15,
  input  logic [NUM_OF_LOGS-1:0] log_exit,
  output logic [NUM_OF_LOGS-1:0] enable,
  output logic [8:0]             start_offsetX [NUM_OF_LOGS],
  output logic [8:0]             start_offsetY [NUM_OF_LOGS],
  output logic                   spawn_valid,
  output logic [4:0]             spawn_index,
  output logic [NUM_LANES-1:0]   lane_overflow
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [LANE_W-1:0]      r_lane;
  logic                   r_pending;
  logic [4:0]             r_gap [NUM_LANES];

  logic [NUM_OF_LOGS-1:0] r_enable;
  logic [8:0]             r_off_x [NUM_OF_LOGS];
  logic [8:0]             r_off_y [NUM_OF_LOGS];
  logic                   r_spawn_valid;
  logic [4:0]             r_spawn_index;
  logic [NUM_LANES-1:0]   r_overflow;

  logic [4:0]             w_gap_cur;
  logic                   w_gap_hit;
  logic                   w_last_lane;
  logic [4:0]             w_reload;
  logic                   w_found;
  logic [4:0]             w_slot;
  logic                   w_spawn;
  logic [NUM_OF_LOGS-1:0] w_spawn_mask;
  logic [8:0]             w_lane_x;
  logic [8:0]             w_lane_y;

  // Gap counter of the lane being scanned (select by compare, never out of range)
  always_comb begin
    w_gap_cur = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (LANE_W'(k) == r_lane) w_gap_cur = r_gap[k];
    end
  end

  assign w_gap_hit   = (r_state == S_SCAN) && (w_gap_cur == 5'd1);
  assign w_last_lane = (r_lane == LANE_W'(NUM_LANES - 1));
  assign w_reload    = 5'(MIN_GAP) + {1'b0, random_0_15};

  // Lowest free slot of the scanned lane; an exiting slot counts as free
  always_comb begin
    w_found = 1'b0;
    w_slot  = '0;
    for (int i = NUM_OF_LOGS - 1; i >= 0; i--) begin
      if (((i / LOGS_PER_LANE) == int'(r_lane)) && (!r_enable[i] || log_exit[i])) begin
        w_found = 1'b1;
        w_slot  = 5'(i);
      end
    end
  end

  assign w_spawn      = w_gap_hit && w_found;
  assign w_spawn_mask = w_spawn ? (NUM_OF_LOGS'(1) << w_slot) : '0;

  // Odd lanes run leftward, so their logs enter from the right edge
  assign w_lane_x = r_lane[0] ? 9'(RIGHT_EDGE_X) : 9'd0;
  assign w_lane_y = 9'(FIRST_LANE_Y) + 9'(LANE_HEIGHT) * 9'(r_lane);

  // Sequencer: state, lane pointer, held tick and per-lane gap counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_pending <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) r_gap[k] <= 5'(k + 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (game_run) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!game_run) begin
            r_state <= S_IDLE;
          end else if (timer_done || r_pending) begin
            r_state   <= S_SCAN;
            r_lane    <= '0;
            // a fresh tick arriving while one is already held stays held
            r_pending <= r_pending & timer_done;
          end
        end
        S_SCAN: begin
          if (timer_done) r_pending <= 1'b1;
          for (int k = 0; k < NUM_LANES; k++) begin
            if (LANE_W'(k) == r_lane) begin
              r_gap[k] <= (w_gap_cur == 5'd1) ? w_reload : (r_gap[k] - 5'd1);
            end
          end
          if (w_last_lane) begin
            r_state <= game_run ? S_RUN : S_IDLE;
            r_lane  <= '0;
          end else begin
            r_lane <= r_lane + LANE_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slot pool: exits clear enables, a spawn sets its slot (spawn wins a tie)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_enable      <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_index <= '0;
      r_overflow    <= '0;
      for (int i = 0; i < NUM_OF_LOGS; i++) begin
        r_off_x[i] <= '0;
        r_off_y[i] <= '0;
      end
    end else begin
      r_enable      <= (r_enable & ~log_exit) | w_spawn_mask;
      r_spawn_valid <= w_spawn;
      if (w_spawn) r_spawn_index <= w_slot;
      for (int i = 0; i < NUM_OF_LOGS; i++) begin
        if (w_spawn_mask[i]) begin
          r_off_x[i] <= w_lane_x;
          r_off_y[i] <= w_lane_y;
        end
      end
      for (int k = 0; k < NUM_LANES; k++) begin
        if (w_gap_hit && !w_found && (LANE_W'(k) == r_lane)) r_overflow[k] <= 1'b1;
      end
    end
  end

  assign enable        = r_enable;
  assign start_offsetX = r_off_x;
  assign start_offsetY = r_off_y;
  assign spawn_valid   = r_spawn_valid;
  assign spawn_index   = r_spawn_index;
  assign lane_overflow = r_overflow;

endmodule

// File: doc/log_spawner.md
Name: log_spawner

Overview:
- Upstream feeder of the multi-log generator. It owns the 30-slot log pool.
- It decides when and where each log appears: it drives the per-slot `enable` vector and the 9-bit `start_offsetX`/`start_offsetY` arrays that the log movers latch.
- Spawning is paced by the game `timer_done` tick. Per-lane gap counters are reloaded from `random_0_15`.
- Slots are freed by exit pulses from the movers.

Parameters:
- NUM_OF_LOGS, 30, total log slots. Must equal NUM_LANES*LOGS_PER_LANE.
- NUM_LANES, 5, river lanes.
- LOGS_PER_LANE, 6, slots per lane. Lane k owns slots k*6 .. k*6+5.
- FIRST_LANE_Y, 64, Y offset of lane 0.
- LANE_HEIGHT, 32, Y pitch between lanes.
- RIGHT_EDGE_X, 448, spawn X for odd (leftward) lanes.
- MIN_GAP, 2, minimum ticks between spawns in one lane.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- game_run  in  1  1 = spawning allowed; 0 = freeze (no spawns, counters hold).
- timer_done  in  1  one-cycle spawn tick.
- random_0_15  in  4  random value, sampled at reload.
- log_exit  in  30  per-slot one-cycle pulse: log left the screen.
- enable  out  30  per-slot active flag.
- start_offsetX  out  9 x 30  unpacked array, spawn X per slot.
- start_offsetY  out  9 x 30  unpacked array, spawn Y per slot.
- spawn_valid  out  1  one-cycle pulse on each spawn.
- spawn_index  out  5  slot spawned when spawn_valid=1.
- lane_overflow  out  5  sticky per-lane flag: spawn dropped because the lane was full.

Behaviour:
- Reset (RESET=1 at a CLK edge, takes priority over everything):
  - enable=0, all offsets=0, spawn_valid=0, spawn_index=0, lane_overflow=0.
  - Gap counter of lane k = k+1. pending=0. FSM=IDLE.
- FSM states: IDLE, RUN, SCAN.
  - IDLE -> RUN when game_run=1.
  - RUN -> SCAN on timer_done=1 with game_run=1. Scan lane pointer L=0.
  - SCAN processes exactly one lane per cycle, L=0..NUM_LANES-1. After the lane-4 cycle -> RUN (or IDLE if game_run=0).
  - game_run=0 in RUN -> IDLE. game_run=0 mid-SCAN: the current scan completes, then -> IDLE.
- timer_done arriving during SCAN sets pending. When pending=1 on return to RUN: next cycle goes straight to SCAN and clears pending. Only one pending tick is held; extra ticks are dropped.
- Per-lane processing in the SCAN cycle for lane L:
  - Gap counter != 1: decrement, no spawn.
  - Gap counter == 1: reload counter = MIN_GAP + random_0_15 (5-bit, max 17). Then search for a free slot.
  - Free slot = enable[i]=0, or log_exit[i]=1 in the same cycle.
  - Pick the lowest-index free slot i in lane L and register:
    - enable[i]=1.
    - start_offsetY[i] = FIRST_LANE_Y + L*LANE_HEIGHT (truncated to 9 bits).
    - start_offsetX[i] = 0 for even L, RIGHT_EDGE_X for odd L.
    - spawn_valid=1, spawn_index=i.
  - All of these are visible the cycle after the SCAN cycle (1-cycle latency).
  - No free slot: no spawn, lane_overflow[L] <= 1 (cleared only by RESET). The counter is still reloaded.
- log_exit[i]=1 clears enable[i] next cycle, in any state including IDLE.
- If a spawn allocates the same slot in the same cycle as its exit pulse, spawn wins: enable[i] stays 1 with the new offsets.
- Offsets of exited slots hold their last value. Movers only sample offsets while enable is high.
- At most one spawn per cycle. spawn_valid is high for exactly one cycle per spawn.
- Enable changes affect no other lane's counter.

Test Plan:
- Reset, game_run=1, random_0_15=0, single timer_done tick:
  - Lane 0 spawns slot 0: enable=30'h1, start_offsetY[0]=64, start_offsetX[0]=0, spawn_valid pulse with spawn_index=0.
  - Lane 0 counter reloads to 2. Other lanes decrement.
- Continue ticks with random=0:
  - Tick 2: lane 1 spawns slot 6, X=448, Y=96.
  - Tick 3: lane 0 slot 1 and lane 2 slot 12 spawn on consecutive cycles, never in the same cycle.
- Fill lane 0 (6 spawns, no exits), then force the next lane-0 spawn -> no enable change in slots 0-5, lane_overflow=5'b00001.
- Full lane 0 with log_exit[3] pulsed in the same cycle as the lane-0 SCAN -> slot 3 re-spawned, enable[3] stays 1, spawn_index=3.
- Two timer_done pulses 2 cycles apart -> second is held as pending; a second SCAN starts immediately after the first. A third pulse during that SCAN with pending already set is dropped.
- RESET asserted mid-SCAN at lane 2 -> next cycle all outputs are 0, FSM=IDLE, lane counters=1..5.
- game_run=0 held during 5 timer_done ticks -> no spawns, counters unchanged, log_exit still clears enable bits.
